op_stack: RTL and testbench

OP_STACK -- requirements
Module: op_stack

---
 rtl/op_stack_pkg.sv | 26 ++
 rtl/stack_mem.sv | 24 ++
 rtl/op_stack.sv | 128 ++++++++++++
 tb/tb_op_stack.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/op_stack_pkg.sv
// Shared processor constants: default datapath width, stack depth and the
// width helpers used by the operand stack and the ALU.
package op_stack_pkg;

   localparam int unsigned NUBITS_DEF = 32;
   localparam int unsigned SDEPTH_DEF = 10;

   // Bits needed to hold a count in the range 0..n inclusive.
   function automatic int unsigned clog2_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // One decoded request per cycle, already resolved by priority and stack level.
   typedef enum logic [3:0] {
      OP_IDLE,
      OP_CLR,
      OP_PUSH,
      OP_OVF,
      OP_POP,
      OP_POP_LAST,
      OP_UNF,
      OP_REPLACE,
      OP_PUSH_UNF
   } stack_op_e;

endpackage

// File: rtl/stack_mem.sv
// Operand stack storage: one synchronous write port, one asynchronous read port.
module stack_mem #(
   parameter int unsigned NUBITS = 32,
   parameter int unsigned SDEPTH = 10,
   parameter int unsigned AW     = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [NUBITS-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [NUBITS-1:0] rdata
);

   logic [NUBITS-1:0] mem [SDEPTH];

   // NOTE: storage has no reset; the stack count marks which entries are valid.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/op_stack.sv
// Operand stack: count, registered top-of-stack, sticky overflow/underflow flags,
// and request priority (clr over push/pop); entries live in stack_mem.
module op_stack
   import op_stack_pkg::*;
#(
   parameter int unsigned NUBITS = NUBITS_DEF,
   parameter int unsigned SDEPTH = SDEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clr,
   input  logic signed [NUBITS-1:0] in,
   output logic signed [NUBITS-1:0] out,
   output logic                     empty,
   output logic                     full,
   output logic                     ovf,
   output logic                     unf
);

   localparam int unsigned SPW = clog2_w(SDEPTH);
   localparam int unsigned AW  = $clog2(SDEPTH);
   localparam logic [SPW-1:0] SP_ZERO = '0;
   localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
   localparam logic [SPW-1:0] SP_TWO  = SPW'(2);
   localparam logic [SPW-1:0] SP_FULL = SPW'(SDEPTH);

   logic [SPW-1:0]          sp, sp_nxt;
   logic [NUBITS-1:0]       tos, tos_nxt;
   logic                    ovf_nxt, unf_nxt;
   logic                    we;
   logic [AW-1:0]           waddr;
   logic [AW-1:0]           raddr;
   logic [NUBITS-1:0]       rdata;
   logic [SPW-1:0]          sp_m1, sp_m2;
   stack_op_e               op;

   assign sp_m1 = sp - SP_ONE;
   assign sp_m2 = sp - SP_TWO;
   // Entry just below the top; only consumed when sp >= 2.
   assign raddr = sp_m2[AW-1:0];

   stack_mem #(
      .NUBITS (NUBITS),
      .SDEPTH (SDEPTH),
      .AW     (AW)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (in),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_comb begin
      op = OP_IDLE;
      if (clr)                op = OP_CLR;
      else if (push && pop)   op = (sp == SP_ZERO) ? OP_PUSH_UNF : OP_REPLACE;
      else if (push)          op = (sp == SP_FULL) ? OP_OVF : OP_PUSH;
      else if (pop) begin
         if (sp == SP_ZERO)     op = OP_UNF;
         else if (sp == SP_ONE) op = OP_POP_LAST;
         else                   op = OP_POP;
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      sp_nxt  = sp;
      tos_nxt = tos;
      ovf_nxt = ovf;
      unf_nxt = unf;
      we      = 1'b0;
      waddr   = sp[AW-1:0];
      unique case (op)
         OP_CLR: begin
            sp_nxt  = SP_ZERO;
            tos_nxt = '0;
            ovf_nxt = 1'b0;
            unf_nxt = 1'b0;
         end
         OP_PUSH, OP_PUSH_UNF: begin
            we      = 1'b1;
            sp_nxt  = sp + SP_ONE;
            tos_nxt = in;
            if (op == OP_PUSH_UNF) unf_nxt = 1'b1;
         end
         OP_OVF:      ovf_nxt = 1'b1;
         OP_UNF:      unf_nxt = 1'b1;
         OP_POP: begin
            sp_nxt  = sp_m1;
            tos_nxt = rdata;
         end
         OP_POP_LAST: begin
            sp_nxt  = SP_ZERO;
            tos_nxt = '0;
         end
         OP_REPLACE: begin
            we      = 1'b1;
            waddr   = sp_m1[AW-1:0];
            tos_nxt = in;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp  <= SP_ZERO;
         tos <= '0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         sp  <= sp_nxt;
         tos <= tos_nxt;
         ovf <= ovf_nxt;
         unf <= unf_nxt;
      end
   end

   assign out   = tos;
   assign empty = (sp == SP_ZERO);
   assign full  = (sp == SP_FULL);

endmodule

// File: tb/tb_op_stack.sv
// Self-checking bench for op_stack (SDEPTH=4): queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_op_stack;

   localparam int unsigned W     = 32;
   localparam int unsigned DEPTH = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                push = 1'b0;
   logic                pop  = 1'b0;
   logic                clr  = 1'b0;
   logic signed [W-1:0] din  = '0;
   logic signed [W-1:0] out;
   logic                empty, full, ovf, unf;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   // Reference model: stack contents as a queue, top is the last element.
   logic signed [W-1:0] q[$];
   logic                m_ovf = 1'b0;
   logic                m_unf = 1'b0;

   op_stack #(.NUBITS(W), .SDEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .clr   (clr),
      .in    (din),
      .out   (out),
      .empty (empty),
      .full  (full),
      .ovf   (ovf),
      .unf   (unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                  name, $signed(act), act, $signed(exp), exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (clr) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (push && pop) begin
         if (q.size() == 0) begin
            m_unf = 1'b1;
            q.push_back(din);
         end else begin
            q[q.size()-1] = din;
         end
      end else if (push) begin
         if (q.size() == DEPTH) m_ovf = 1'b1;
         else                   q.push_back(din);
      end else if (pop) begin
         if (q.size() == 0) m_unf = 1'b1;
         else               void'(q.pop_back());
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_out",   out, (q.size() == 0) ? '0 : q[q.size()-1]);
         check("model_empty", {31'd0, empty}, {31'd0, q.size() == 0});
         check("model_full",  {31'd0, full},  {31'd0, q.size() == DEPTH});
         check("model_ovf",   {31'd0, ovf},   {31'd0, m_ovf});
         check("model_unf",   {31'd0, unf},   {31'd0, m_unf});
      end
   end

   task automatic do_op(input logic p, input logic o, input logic c, input logic signed [W-1:0] d);
      @(negedge clk);
      push = p;
      pop  = o;
      clr  = c;
      din  = d;
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
      clr  = 1'b0;
   endtask

   task automatic expect_flags(input string tag, input logic e, input logic f,
                               input logic ov, input logic un);
      check({tag, "_empty"}, {31'd0, empty}, {31'd0, e});
      check({tag, "_full"},  {31'd0, full},  {31'd0, f});
      check({tag, "_ovf"},   {31'd0, ovf},   {31'd0, ov});
      check({tag, "_unf"},   {31'd0, unf},   {31'd0, un});
   endtask

   initial begin
      logic signed [W-1:0] fill_vals [4];
      logic signed [W-1:0] pop_vals  [4];
      fill_vals = '{32'sd5, -32'sd3, 32'sd7, 32'sd9};
      pop_vals  = '{32'sd7, -32'sd3, 32'sd5, 32'sd0};

      #12;
      check("reset_out", out, '0);
      expect_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst    = 1'b1;
      cmp_en = 1'b1;

      do_op(1'b0, 1'b1, 1'b0, '0);
      check("empty_pop_out", out, '0);
      expect_flags("empty_pop", 1'b1, 1'b0, 1'b0, 1'b1);
      do_op(1'b0, 1'b0, 1'b1, '0);
      expect_flags("clr_unf", 1'b1, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, 1'b0, fill_vals[i]);
      check("fill_out", out, 32'sd9);
      expect_flags("fill", 1'b0, 1'b1, 1'b0, 1'b0);
      do_op(1'b1, 1'b0, 1'b0, 32'sd11);
      check("ovf_out", out, 32'sd9);
      expect_flags("ovf", 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         do_op(1'b0, 1'b1, 1'b0, '0);
         check($sformatf("pop%0d_out", i), out, pop_vals[i]);
      end
      expect_flags("drained", 1'b1, 1'b0, 1'b1, 1'b0);

      do_op(1'b0, 1'b0, 1'b1, '0);
      do_op(1'b1, 1'b0, 1'b0, 32'sd5);
      do_op(1'b1, 1'b0, 1'b0, 32'sd7);
      do_op(1'b1, 1'b1, 1'b0, 32'sd42);
      check("replace_out", out, 32'sd42);
      do_op(1'b0, 1'b1, 1'b0, '0);
      check("replace_pop_out", out, 32'sd5);
      do_op(1'b0, 1'b1, 1'b0, '0);
      expect_flags("replace_drained", 1'b1, 1'b0, 1'b0, 1'b0);

      for (int i = 1; i <= 4; i++) do_op(1'b1, 1'b0, 1'b0, W'(i));
      do_op(1'b1, 1'b1, 1'b0, -32'sd1);
      check("full_replace_out", out, 32'hFFFF_FFFF);
      expect_flags("full_replace", 1'b0, 1'b1, 1'b0, 1'b0);
      do_op(1'b0, 1'b1, 1'b0, '0);
      check("full_replace_pop", out, 32'sd3);

      do_op(1'b0, 1'b0, 1'b1, '0);
      do_op(1'b1, 1'b1, 1'b0, 32'sd8);
      check("empty_pushpop_out", out, 32'sd8);
      expect_flags("empty_pushpop", 1'b0, 1'b0, 1'b0, 1'b1);

      do_op(1'b0, 1'b0, 1'b1, '0);
      for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, 1'b0, W'(100 + i));
      check("three_out", out, 32'sd102);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_out", out, '0);
      expect_flags("async_rst", 1'b1, 1'b0, 1'b0, 1'b0);
      #1 rst = 1'b1;

      do_op(1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 1'b0, W'(200 + i));
      do_op(1'b0, 1'b1, 1'b0, '0);
      check("pre_clr_out", out, 32'sd202);
      expect_flags("pre_clr", 1'b0, 1'b0, 1'b1, 1'b1);
      do_op(1'b1, 1'b1, 1'b1, 32'sd55);
      check("clr_out", out, '0);
      expect_flags("clr", 1'b1, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      push = 1'b1;
      din  = 32'sd99;
      rst  = 1'b0;
      @(posedge clk);
      #1;
      check("rst_discard_out", out, '0);
      expect_flags("rst_discard", 1'b1, 1'b0, 1'b0, 1'b0);
      push = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      do_op(1'b1, 1'b0, 1'b0, 32'sd77);
      check("post_rst_push", out, 32'sd77);

      @(negedge clk);
      @(negedge clk);
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
